// File: rtl/mda_vram_if.sv
// Signal bundle between the MDA VRAM scheduler and its CRTC, CPU and VRAM neighbours.
// The slave side is the scheduler; the master side drives requests and models the RAM.
interface mda_vram_if;
    logic        char_start;
    logic        display_enable;
    logic [10:0] crtc_addr;
    logic        vsync;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [11:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [7:0]  char_byte;
    logic [7:0]  att_byte;
    logic        blink;
    logic        overrun;

    modport slave (
        input  char_start, display_enable, crtc_addr, vsync,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
        output cpu_ack, cpu_rdata, vram_addr, vram_we, vram_wdata,
        output char_byte, att_byte, blink, overrun
    );

    modport master (
        output char_start, display_enable, crtc_addr, vsync,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
        input  cpu_ack, cpu_rdata, vram_addr, vram_we, vram_wdata,
        input  char_byte, att_byte, blink, overrun
    );
endinterface

// File: rtl/mda_vram_sched.sv
// Single-port VRAM arbiter for an MDA-style display: interleaves char/attribute
// fetches with CPU accesses and derives the cursor/attribute blink from vsync.
module mda_vram_sched #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    mda_vram_if.slave   bus
);

    typedef enum logic [1:0] {
        ISS_NONE = 2'd0,
        ISS_CHAR = 2'd1,
        ISS_ATT  = 2'd2,
        ISS_CPU  = 2'd3
    } issue_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    issue_t      issue_reg;
    issue_t      issue_next;
    issue_t      tag_reg;
    logic        tag_we_reg;
    logic        cpu_busy_reg;
    logic [10:0] crtc_latch_reg;
    logic [7:0]  char_hold_reg;
    logic        overrun_next;

    logic [11:0] vram_addr_reg;
    logic        vram_we_reg;
    logic [7:0]  vram_wdata_reg;
    logic [7:0]  char_byte_reg;
    logic [7:0]  att_byte_reg;
    logic [7:0]  cpu_rdata_reg;
    logic        cpu_ack_reg;
    logic        overrun_reg;

    logic        vsync_meta_reg;
    logic        vsync_sync_reg;
    logic        vsync_prev_reg;
    logic [7:0]  blink_cnt_reg;
    logic        blink_reg;

    // An attribute fetch always follows its char fetch, so a CHAR issue last
    // cycle pre-empts both a new char_start and the CPU.
    always_comb begin
        issue_next = ISS_NONE;
        if (issue_reg == ISS_CHAR)
            issue_next = ISS_ATT;
        else if (bus.char_start && bus.display_enable)
            issue_next = ISS_CHAR;
        else if (bus.cpu_req && !cpu_busy_reg)
            issue_next = ISS_CPU;
    end

    assign overrun_next = bus.char_start && bus.display_enable && (issue_reg == ISS_CHAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_reg      <= ISS_NONE;
            tag_reg        <= ISS_NONE;
            tag_we_reg     <= 1'b0;
            cpu_busy_reg   <= 1'b0;
            crtc_latch_reg <= '0;
            char_hold_reg  <= '0;
            vram_addr_reg  <= '0;
            vram_we_reg    <= 1'b0;
            vram_wdata_reg <= '0;
            char_byte_reg  <= '0;
            att_byte_reg   <= '0;
            cpu_rdata_reg  <= '0;
            cpu_ack_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            issue_reg   <= issue_next;
            tag_reg     <= issue_reg;
            tag_we_reg  <= vram_we_reg;
            overrun_reg <= overrun_next;
            cpu_ack_reg <= 1'b0;
            vram_we_reg <= 1'b0;

            // busy is still set while ack is high, so no grant collides with this clear
            if (cpu_ack_reg)
                cpu_busy_reg <= 1'b0;

            case (issue_next)
                ISS_CHAR: begin
                    vram_addr_reg  <= {bus.crtc_addr, 1'b0};
                    crtc_latch_reg <= bus.crtc_addr;
                end
                ISS_ATT: begin
                    vram_addr_reg <= {crtc_latch_reg, 1'b1};
                end
                ISS_CPU: begin
                    vram_addr_reg  <= bus.cpu_addr;
                    vram_we_reg    <= bus.cpu_we;
                    vram_wdata_reg <= bus.cpu_wdata;
                    cpu_busy_reg   <= 1'b1;
                end
                default: ;
            endcase

            // The char byte is parked until its attribute arrives so both update together.
            case (tag_reg)
                ISS_CHAR: char_hold_reg <= bus.vram_rdata;
                ISS_ATT: begin
                    char_byte_reg <= char_hold_reg;
                    att_byte_reg  <= bus.vram_rdata;
                end
                ISS_CPU: begin
                    cpu_ack_reg <= 1'b1;
                    if (!tag_we_reg)
                        cpu_rdata_reg <= bus.vram_rdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_meta_reg <= 1'b0;
            vsync_sync_reg <= 1'b0;
            vsync_prev_reg <= 1'b0;
            blink_cnt_reg  <= '0;
            blink_reg      <= 1'b0;
        end else begin
            vsync_meta_reg <= bus.vsync;
            vsync_sync_reg <= vsync_meta_reg;
            vsync_prev_reg <= vsync_sync_reg;
            if (vsync_sync_reg && !vsync_prev_reg) begin
                if (blink_cnt_reg == BLINK_LAST) begin
                    blink_cnt_reg <= '0;
                    blink_reg     <= ~blink_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign bus.vram_addr  = vram_addr_reg;
    assign bus.vram_we    = vram_we_reg;
    assign bus.vram_wdata = vram_wdata_reg;
    assign bus.char_byte  = char_byte_reg;
    assign bus.att_byte   = att_byte_reg;
    assign bus.cpu_rdata  = cpu_rdata_reg;
    assign bus.cpu_ack    = cpu_ack_reg;
    assign bus.overrun    = overrun_reg;
    assign bus.blink      = blink_reg;

endmodule

// File: tb/tb_mda_vram_sched.sv
// Directed bench for mda_vram_sched: per-cycle vector table for fetch/CPU/collision/
// overrun behaviour, then hand sequences for blink and reset during a CPU access.
module tb_mda_vram_sched;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mda_vram_if vif ();

    mda_vram_sched #(.BLINK_FRAMES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM model; preloaded on the first clock edge.
    logic [7:0] ram [4096];
    bit         ram_loaded;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            ram[12'h00A] <= 8'h41;
            ram[12'h00B] <= 8'h70;
            ram[12'h014] <= 8'h42;
            ram[12'h015] <= 8'h1F;
            ram[12'h00E] <= 8'h43;
            ram[12'h00F] <= 8'h07;
            ram_loaded   <= 1'b1;
        end else if (vif.vram_we) begin
            ram[vif.vram_addr] <= vif.vram_wdata;
        end
        vif.vram_rdata <= ram[vif.vram_addr];
    end

    typedef struct {
        logic        cs;
        logic        de;
        logic [10:0] ca;
        logic        req;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wd;
        logic [11:0] e_va;
        logic        e_we;
        logic        e_ack;
        logic        e_ovr;
        logic [7:0]  e_cb;
        logic [7:0]  e_ab;
        logic [7:0]  e_rd;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        //          cs    de    ca      req   we    addr     wd      | va      we    ack   ovr   cb     ab     rd
        vecs[0]  = '{1'b1, 1'b1, 11'h005, 1'b0, 1'b0, 12'h000, 8'h00, 12'h000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h00A, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h00B, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h00B, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 12'h123, 8'h5A, 12'h00B, 1'b0, 1'b0, 1'b0, 8'h41, 8'h70, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 12'h123, 8'h5A, 12'h123, 1'b1, 1'b0, 1'b0, 8'h41, 8'h70, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b1, 12'h123, 8'h5A, 12'h123, 1'b0, 1'b0, 1'b0, 8'h41, 8'h70, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h123, 1'b0, 1'b1, 1'b0, 8'h41, 8'h70, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 12'h123, 8'h00, 12'h123, 1'b0, 1'b0, 1'b0, 8'h41, 8'h70, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 12'h123, 8'h00, 12'h123, 1'b0, 1'b0, 1'b0, 8'h41, 8'h70, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 12'h123, 8'h00, 12'h123, 1'b0, 1'b0, 1'b0, 8'h41, 8'h70, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h123, 1'b0, 1'b1, 1'b0, 8'h41, 8'h70, 8'h5A};
        vecs[12] = '{1'b1, 1'b1, 11'h00A, 1'b1, 1'b0, 12'h00A, 8'h00, 12'h123, 1'b0, 1'b0, 1'b0, 8'h41, 8'h70, 8'h5A};
        vecs[13] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 12'h00A, 8'h00, 12'h014, 1'b0, 1'b0, 1'b0, 8'h41, 8'h70, 8'h5A};
        vecs[14] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 12'h00A, 8'h00, 12'h015, 1'b0, 1'b0, 1'b0, 8'h41, 8'h70, 8'h5A};
        vecs[15] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 12'h00A, 8'h00, 12'h00A, 1'b0, 1'b0, 1'b0, 8'h41, 8'h70, 8'h5A};
        vecs[16] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 12'h00A, 8'h00, 12'h00A, 1'b0, 1'b0, 1'b0, 8'h42, 8'h1F, 8'h5A};
        vecs[17] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h00A, 1'b0, 1'b1, 1'b0, 8'h42, 8'h1F, 8'h41};
        vecs[18] = '{1'b1, 1'b1, 11'h007, 1'b0, 1'b0, 12'h000, 8'h00, 12'h00A, 1'b0, 1'b0, 1'b0, 8'h42, 8'h1F, 8'h41};
        vecs[19] = '{1'b1, 1'b1, 11'h00A, 1'b0, 1'b0, 12'h000, 8'h00, 12'h00E, 1'b0, 1'b0, 1'b0, 8'h42, 8'h1F, 8'h41};
        vecs[20] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h00F, 1'b0, 1'b0, 1'b1, 8'h42, 8'h1F, 8'h41};
        vecs[21] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h00F, 1'b0, 1'b0, 1'b0, 8'h42, 8'h1F, 8'h41};
        vecs[22] = '{1'b1, 1'b0, 11'h00A, 1'b1, 1'b0, 12'h014, 8'h00, 12'h00F, 1'b0, 1'b0, 1'b0, 8'h43, 8'h07, 8'h41};
        vecs[23] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 12'h014, 8'h00, 12'h014, 1'b0, 1'b0, 1'b0, 8'h43, 8'h07, 8'h41};
        vecs[24] = '{1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 12'h014, 8'h00, 12'h014, 1'b0, 1'b0, 1'b0, 8'h43, 8'h07, 8'h41};
        vecs[25] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h014, 1'b0, 1'b1, 1'b0, 8'h43, 8'h07, 8'h42};
        vecs[26] = '{1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 12'h000, 8'h00, 12'h014, 1'b0, 1'b0, 1'b0, 8'h43, 8'h07, 8'h42};

        rst_n              = 1'b0;
        vif.char_start     = 1'b0;
        vif.display_enable = 1'b0;
        vif.crtc_addr      = '0;
        vif.vsync          = 1'b0;
        vif.cpu_req        = 1'b0;
        vif.cpu_we         = 1'b0;
        vif.cpu_addr       = '0;
        vif.cpu_wdata      = '0;
        repeat (3) tick();

        chk("rst_vram_addr", 0, 12'(vif.vram_addr), 12'h000);
        chk("rst_vram_we",   0, 12'(vif.vram_we),   12'h000);
        chk("rst_cpu_ack",   0, 12'(vif.cpu_ack),   12'h000);
        chk("rst_overrun",   0, 12'(vif.overrun),   12'h000);
        chk("rst_char_byte", 0, 12'(vif.char_byte), 12'h000);
        chk("rst_att_byte",  0, 12'(vif.att_byte),  12'h000);
        chk("rst_cpu_rdata", 0, 12'(vif.cpu_rdata), 12'h000);
        chk("rst_blink",     0, 12'(vif.blink),     12'h000);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            chk("vram_addr", i, 12'(vif.vram_addr), vecs[i].e_va);
            chk("vram_we",   i, 12'(vif.vram_we),   12'(vecs[i].e_we));
            chk("cpu_ack",   i, 12'(vif.cpu_ack),   12'(vecs[i].e_ack));
            chk("overrun",   i, 12'(vif.overrun),   12'(vecs[i].e_ovr));
            chk("char_byte", i, 12'(vif.char_byte), 12'(vecs[i].e_cb));
            chk("att_byte",  i, 12'(vif.att_byte),  12'(vecs[i].e_ab));
            chk("cpu_rdata", i, 12'(vif.cpu_rdata), 12'(vecs[i].e_rd));
            $display("[TB] cycle %0d: vram_addr=0x%03h we=%0b ack=%0b ovr=%0b char=0x%02h att=0x%02h rdata=0x%02h",
                     i, vif.vram_addr, vif.vram_we, vif.cpu_ack, vif.overrun,
                     vif.char_byte, vif.att_byte, vif.cpu_rdata);
            vif.char_start     = vecs[i].cs;
            vif.display_enable = vecs[i].de;
            vif.crtc_addr      = vecs[i].ca;
            vif.cpu_req        = vecs[i].req;
            vif.cpu_we         = vecs[i].we;
            vif.cpu_addr       = vecs[i].addr;
            vif.cpu_wdata      = vecs[i].wd;
            tick();
        end

        // Blink: each vsync pulse is held high several cycles but must count once.
        for (int n = 1; n <= 40; n++) begin
            vif.vsync = 1'b1;
            repeat (3) tick();
            vif.vsync = 1'b0;
            repeat (4) tick();
            chk("blink", n, 12'(vif.blink), 12'((n >= 16 && n < 32) ? 1 : 0));
            $display("[TB] vsync pulse %0d: blink=%0b", n, vif.blink);
        end

        // Reset asserted during the data cycle of a CPU read.
        vif.cpu_req  = 1'b1;
        vif.cpu_we   = 1'b0;
        vif.cpu_addr = 12'h123;
        tick();
        chk("rm_grant_addr", 0, 12'(vif.vram_addr), 12'h123);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rm_ack",       0, 12'(vif.cpu_ack),   12'h000);
        chk("rm_vram_addr", 0, 12'(vif.vram_addr), 12'h000);
        chk("rm_cpu_rdata", 0, 12'(vif.cpu_rdata), 12'h000);
        chk("rm_char_byte", 0, 12'(vif.char_byte), 12'h000);
        chk("rm_att_byte",  0, 12'(vif.att_byte),  12'h000);
        chk("rm_vram_we",   0, 12'(vif.vram_we),   12'h000);
        chk("rm_blink",     0, 12'(vif.blink),     12'h000);
        tick();
        chk("rm_ack", 1, 12'(vif.cpu_ack), 12'h000);
        tick();
        chk("rm_ack", 2, 12'(vif.cpu_ack), 12'h000);
        rst_n = 1'b1;
        $display("[TB] reset mid-access: reset released with cpu_req held");
        chk("rm_regrant_ack", 0, 12'(vif.cpu_ack), 12'h000);
        tick();
        chk("rm_regrant_ack",  1, 12'(vif.cpu_ack),   12'h000);
        chk("rm_regrant_addr", 1, 12'(vif.vram_addr), 12'h123);
        tick();
        chk("rm_regrant_ack", 2, 12'(vif.cpu_ack), 12'h000);
        tick();
        chk("rm_regrant_ack",   3, 12'(vif.cpu_ack),   12'h001);
        chk("rm_regrant_rdata", 3, 12'(vif.cpu_rdata), 12'h05A);
        $display("[TB] reset mid-access: ack=%0b rdata=0x%02h", vif.cpu_ack, vif.cpu_rdata);
        vif.cpu_req = 1'b0;
        tick();
        chk("rm_regrant_ack", 4, 12'(vif.cpu_ack), 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mda_vram_sched.md
MDA_VRAM_SCHED -- requirements
Module: mda_vram_sched

Interface
REQ-001 Parameter BLINK_FRAMES, default 16: vsync rising edges per toggle of blink.
REQ-002 Port clk, input, 1: single clock for all logic.
REQ-003 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 Port char_start, input, 1: one-cycle pulse requesting fetch of the next character cell.
REQ-005 Port display_enable, input, 1: CRTC active-display flag, sampled with char_start.
REQ-006 Port crtc_addr, input, 11: character cell index, sampled with char_start.
REQ-007 Port vsync, input, 1: CRTC vertical sync, asynchronous to the fetch schedule.
REQ-008 Ports cpu_req (in, 1), cpu_we (in, 1), cpu_addr (in, 12), cpu_wdata (in, 8): CPU VRAM request, held stable until cpu_ack.
REQ-009 Ports cpu_ack (out, 1) and cpu_rdata (out, 8): CPU completion pulse and read data.
REQ-010 Ports vram_addr (out, 12), vram_we (out, 1), vram_wdata (out, 8), vram_rdata (in, 8): single-port synchronous VRAM; read data valid one cycle after address.
REQ-011 Ports char_byte (out, 8) and att_byte (out, 8): fetched character and attribute for the attribute/pixel path.
REQ-012 Port blink (out, 1): cursor-rate blink for the attribute stage.
REQ-013 Port overrun (out, 1): one-cycle pulse when a char_start is dropped.

Function
REQ-014 Issue stage SHALL decide at each clk edge, priority: (1) ATT, if CHAR was issued the previous cycle; (2) CHAR, if char_start and display_enable; (3) CPU, if cpu_req and not cpu_busy; (4) NONE.
REQ-015 Issue outputs SHALL be registered.
- CHAR: vram_addr = {crtc_addr,0}.
- ATT: vram_addr = {latched crtc_addr,1}.
- CPU: vram_addr = cpu_addr, vram_we = cpu_we, vram_wdata = cpu_wdata.
- NONE: vram_we = 0, vram_addr holds.
REQ-016 vram_we SHALL be high only in a CPU-issue cycle with cpu_we = 1.
REQ-017 A 2-bit tag SHALL follow each issue by one cycle and route vram_rdata to the char holding register, att_byte, or cpu_rdata.
REQ-018 Latency from char_start high in cycle T:
- CHAR address driven in T+1, ATT address in T+2.
- char_byte and att_byte update together, visible from T+4.
REQ-019 Latency from CPU grant decided at the edge ending cycle T:
- Access driven in T+1.
- cpu_ack high for exactly one cycle, T+3, with cpu_rdata valid for reads.
- cpu_rdata holds its value after the ack cycle.
REQ-020 cpu_busy SHALL be set at grant and cleared after the ack cycle, so cpu_req is not regranted before T+4.
REQ-021 char_start with display_enable low SHALL issue no fetch, leave char_byte and att_byte unchanged, and leave the slot to the CPU.
REQ-022 char_start while an ATT issue is pending (fetch starts spaced by less than 2 cycles) SHALL be ignored, with overrun pulsed the next cycle.
REQ-023 char_start and cpu_req together SHALL grant CHAR; the CPU is granted in the first later cycle where no fetch issues.
REQ-024 The CPU SHALL wait at most 2 cycles per back-to-back character fetch; there is no starvation guarantee beyond this.
REQ-025 Blink path:
- vsync synchronised through 2 flops; an 8-bit counter counts synchronised rising edges.
- At count BLINK_FRAMES-1, the counter wraps to 0 and blink toggles.
- vsync held high counts once.

Reset
REQ-026 While rst_n is low, all of the following SHALL be 0 and cpu_busy cleared:
- char_byte, att_byte, cpu_rdata, vram_addr, vram_wdata
- cpu_ack, vram_we, overrun, blink
- tag, blink counter, vsync synchronisers.
REQ-027 Reset mid-access SHALL abort without an ack; a requester still holding cpu_req after reset is granted afresh.

Verification
REQ-028 Fetch: rst_n released; char_start at T with crtc_addr=0x005, display_enable=1; RAM[0x00A]=0x41, RAM[0x00B]=0x70 -> vram_addr 0x00A at T+1, 0x00B at T+2; char_byte=0x41 and att_byte=0x70 from T+4; vram_we=0 throughout.
REQ-029 CPU access:
- cpu_req write addr 0x123 data 0x5A, no fetches -> vram_we=1 for one cycle with vram_addr 0x123, cpu_ack 2 cycles later.
- Read of 0x123 -> cpu_rdata=0x5A on ack.
REQ-030 Collision: char_start and cpu_req in the same cycle -> CHAR then ATT issued; CPU issued in the 3rd cycle; ack 2 cycles after that.
REQ-031 Overrun: char_start at T and T+1 -> second pulse ignored, overrun=1 at T+2, one ATT issue only.
REQ-032 Blink: BLINK_FRAMES=16, 40 vsync pulses -> blink toggles at the 16th and 32nd pulses, 0 to 1 to 0.
REQ-033 Reset mid-access: rst_n low during a CPU read's data cycle -> no cpu_ack, all outputs 0; after release, held cpu_req is granted and acked normally.
